// File: rtl/lampfpu_sqrt_round_pack.sv
// lampfpu_sqrt_round_pack
// Final stage of the square-root unit: rounds the extended significand to
// nearest-even, renormalises on mantissa carry, saturates exponent overflow
// to infinity and packs a {sign, exponent, fraction} float. Packed results
// are buffered in a first-word-fall-through FIFO because the producer cannot
// be stalled.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   valid_i       one-cycle pulse per incoming result
//   isToRound_i   1 = round the result, 0 = special value passed through
//   s_i, e_i, f_i sign, biased exponent, extended significand
//                 f_i = {carry, hidden, fraction, guard, round, sticky}
//   ready_i       consumer takes the head entry while valid_o is high
//   valid_o       FIFO holds at least one entry
//   result_o      packed float at the FIFO head
//   flag_nx_o     inexact flag of the head entry
//   flag_of_o     overflow flag of the head entry
//   count_o       FIFO occupancy
//   overflow_o    sticky, set when a result was dropped on a full FIFO
module lampfpu_sqrt_round_pack #(
   parameter int E_DW  = 8,
   parameter int F_DW  = 7,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_i,
   input  logic                      isToRound_i,
   input  logic                      s_i,
   input  logic [E_DW-1:0]           e_i,
   input  logic [F_DW+4:0]           f_i,
   input  logic                      ready_i,
   output logic                      valid_o,
   output logic [E_DW+F_DW:0]        result_o,
   output logic                      flag_nx_o,
   output logic                      flag_of_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      overflow_o
);

   localparam int RW = 1 + E_DW + F_DW;   // packed result width
   localparam int EW = RW + 2;            // FIFO entry: {result, nx, of}
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int MW = F_DW + 2;          // rounded significand incl. carry
   localparam logic [E_DW-1:0] E_MAX = {E_DW{1'b1}};

   // rounding datapath
   logic            lsb_s, g_s, r_s, st_s, inc_s, nx_s, of_s;
   logic [MW-1:0]   m_s;
   logic [F_DW-1:0] frac_s;
   logic [E_DW:0]   exp_ext_s;
   logic [RW-1:0]   res_s;
   // the incoming carry bit is always 0 and carries no information
   logic            unused_carry_s;

   // stage-1 registers
   logic            s1_valid_r;
   logic [EW-1:0]   s1_entry_r;

   // FIFO
   logic [EW-1:0]   mem_r [DEPTH];
   logic [AW-1:0]   wptr_r, rptr_r;
   logic [CW-1:0]   count_r;
   logic            ovf_r;
   logic            pop_s, full_s, wr_en_s, drop_s;
   logic [EW-1:0]   head_s;

   assign unused_carry_s = f_i[F_DW+4];

   // Round-to-nearest-even, carry renormalisation and overflow saturation
   always_comb begin
      lsb_s     = f_i[3];
      g_s       = f_i[2];
      r_s       = f_i[1];
      st_s      = f_i[0];
      inc_s     = 1'b0;
      nx_s      = 1'b0;
      of_s      = 1'b0;
      frac_s    = '0;
      exp_ext_s = '0;
      res_s     = '0;
      if (isToRound_i) begin
         inc_s = g_s & (r_s | st_s | lsb_s);
         nx_s  = g_s | r_s | st_s;
      end else begin
         inc_s = 1'b0;
         nx_s  = 1'b0;
      end
      m_s = {1'b0, f_i[F_DW+3:3]} + {{(MW-1){1'b0}}, inc_s};
      // a carry out of the hidden bit shifts right by one: fraction becomes 0
      if (m_s[MW-1]) begin
         frac_s    = m_s[F_DW:1];
         exp_ext_s = {1'b0, e_i} + {{E_DW{1'b0}}, 1'b1};
      end else begin
         frac_s    = m_s[F_DW-1:0];
         exp_ext_s = {1'b0, e_i};
      end
      // exp_ext_s is one bit wider, so an all-ones input plus carry is caught too
      if (!isToRound_i) begin
         res_s = {s_i, e_i, f_i[F_DW+2:3]};
      end else if (exp_ext_s >= {1'b0, E_MAX}) begin
         res_s = {s_i, E_MAX, {F_DW{1'b0}}};
         of_s  = 1'b1;
         nx_s  = 1'b1;
      end else begin
         res_s = {s_i, exp_ext_s[E_DW-1:0], frac_s};
      end
   end

   // Stage-1 register: captures the packed result of each valid input
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_entry_r <= '0;
      end else begin
         s1_valid_r <= valid_i;
         if (valid_i) begin
            s1_entry_r <= {res_s, nx_s, of_s};
         end else begin
            s1_entry_r <= s1_entry_r;
         end
      end
   end

   // FIFO control: a full FIFO still accepts a write when the head is popped
   always_comb begin
      pop_s   = (count_r != '0) && ready_i;
      full_s  = (count_r == CW'(DEPTH));
      wr_en_s = s1_valid_r && (!full_s || pop_s);
      drop_s  = s1_valid_r && full_s && !pop_s;
   end

   // FIFO storage, pointers, occupancy and sticky drop flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         ovf_r   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (wr_en_s) begin
            mem_r[wptr_r] <= s1_entry_r;
            wptr_r        <= wptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1'b1);
         end
         if (wr_en_s && !pop_s) begin
            count_r <= count_r + CW'(1'b1);
         end else if (!wr_en_s && pop_s) begin
            count_r <= count_r - CW'(1'b1);
         end else begin
            count_r <= count_r;
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign head_s     = mem_r[rptr_r];
   assign valid_o    = (count_r != '0);
   assign result_o   = head_s[EW-1:2];
   assign flag_nx_o  = head_s[1];
   assign flag_of_o  = head_s[0];
   assign count_o    = count_r;
   assign overflow_o = ovf_r;

endmodule

// File: doc/lampfpu_sqrt_round_pack.md
Name: lampfpu_sqrt_round_pack

Overview:
- Downstream stage of the square-root unit. Consumes its registered {sign, exponent, 12-bit extended significand, isToRound, valid} result.
- Performs round-to-nearest-even, mantissa-carry renormalisation and exponent-overflow saturation, then packs a 16-bit float (1/8/7).
- Buffers packed results in a small first-word-fall-through FIFO with a valid/ready output handshake, because the square-root unit has no backpressure.

Parameters:
- E_DW, 8, exponent width.
- F_DW, 7, stored fraction width; input significand width is F_DW+5.
- DEPTH, 4, result FIFO entries; power of two, 2 or more.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  1  input result valid; single-cycle pulse per result
- isToRound_i  in  1  1 = apply rounding; 0 = special value, pass through unrounded
- s_i  in  1  sign
- e_i  in  E_DW  biased exponent
- f_i  in  F_DW+5  significand: [11] carry (0), [10] hidden, [9:3] fraction, [2] guard, [1] round, [0] sticky
- ready_i  in  1  consumer accepts the head entry when valid_o is high
- valid_o  out  1  FIFO not empty
- result_o  out  1+E_DW+F_DW  packed {s, e, frac} at the FIFO head
- flag_nx_o  out  1  inexact flag of the head entry
- flag_of_o  out  1  overflow flag of the head entry
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: a result was dropped

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset, every output is 0, the FIFO pointers and count are 0, and the stage-1 valid is 0. Reset mid-operation discards all in-flight and buffered results.
- Stage 1 (registered on the edge where valid_i=1):
  - lsb=f_i[3], g=f_i[2], r=f_i[1], st=f_i[0].
  - If isToRound_i: inc = g & (r | st | lsb); nx = g | r | st.
  - If not isToRound_i: inc = 0, nx = 0.
  - m9 = {1'b0, f_i[10:3]} + inc (9 bits).
  - If m9[8]=1: frac = m9[8:1] low F_DW bits (i.e. 0), exp = e_i + 1.
  - Else: frac = m9[6:0], exp = e_i.
  - If isToRound_i and exp == all-ones after increment, or e_i is already all-ones with a carry: result = {s, 8'hFF, 7'h00}, of = 1, nx = 1.
  - If not isToRound_i: e_i and f_i[9:3] pass through unchanged, so NaN payload and Inf/zero encodings are preserved.
  - Stage-1 valid follows valid_i every cycle; there are no bubbles.
- Stage 2: when stage-1 valid is 1, write {result, nx, of} into the FIFO at wptr.
- Latency: valid_i at edge k -> valid_o=1 after edge k+1 if the FIFO was empty. Throughput is 1 result per cycle.
- FIFO:
  - Pop occurs when valid_o & ready_i.
  - Outputs show the head entry combinationally from storage (first-word fall-through).
  - Pointers wrap modulo DEPTH.
  - count_o increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
  - Full with simultaneous push and pop: accepted, count stays DEPTH.
  - Full with push and no pop: the entry is dropped, storage and count are unchanged, and overflow_o is set until reset.
  - Empty: ready_i is ignored, valid_o=0, and result_o holds stale data (don't-care).
  - Push into an empty FIFO with ready_i=1 in the same cycle: no pop that cycle; the entry appears next cycle.

Test Plan:
- Round up: e=0x7F, f=12'b0_1_0000001_100, isToRound=1 -> result 0x3F82, nx=1, of=0, valid_o 2 cycles after valid_i.
- Tie to even: e=0x7F, f=12'b0_1_0000000_100 -> 0x3F80, nx=1; f=12'b0_1_0000000_000 -> 0x3F80, nx=0.
- Carry renormalise: e=0x7F, f=12'b0_1_1111111_110 -> 0x4000, nx=1. Overflow: same f with e=0xFE -> 0x7F80, of=1, nx=1.
- Passthrough: isToRound=0, s=0, e=0xFF, f=12'b0_1_1000000_111 -> 0x7FC0, nx=0, of=0.
- Backpressure: DEPTH=4, ready_i=0, 5 back-to-back valid_i -> count_o=4, overflow_o=1, the first 4 results drain in order once ready_i=1, and the 5th is never seen.
- Full with simultaneous pop: count=4, push and pop in the same cycle -> count stays 4, overflow_o stays 0. Assert rst mid-stream -> valid_o=0 and count_o=0 next cycle.
